// File: rtl/tc_cltu_decode.sv
// ---------------------------------------------------------------------------
// tc_cltu_decode
//
// Telecommand CLTU front end. Hunts the 16-bit start sequence in the
// demodulated bit stream, then collects 64-bit BCH(63,56) codeblocks. Each
// block is checked (and optionally corrected), and its 56 information bits
// are streamed out as one contiguous DataO/En_DataO burst. The tail
// sequence ends the CLTU.
//
// Optional feature macro: TC_BCH_CORRECT_EN
//   defined   : single-bit errors are corrected by a 63-step Meggitt search
//               (CHECK always lasts 63 cycles).
//   undefined : any nonzero remainder rejects the block (CHECK lasts 1 cycle).
//
// Ports
//   Clk        in   system clock
//   Rst        in   asynchronous, active-high reset
//   BitI       in   received bit, sampled when BitEn=1
//   BitEn      in   one-cycle bit strobe (strobes at least 2 Clk apart)
//   DataO      out  decoded info bit, valid while En_DataO=1, else 0
//   En_DataO   out  high for 56 consecutive cycles per good block
//   Block_ErrO out  one-cycle pulse per uncorrectable or overrun block
//   IP_END_O   out  one-cycle pulse on tail sequence detection
//   Lock_O     out  high from start-sequence match until tail/error/reset
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tc_cltu_decode (
  input  logic Clk,
  input  logic Rst,
  input  logic BitI,
  input  logic BitEn,
  output logic DataO,
  output logic En_DataO,
  output logic Block_ErrO,
  output logic IP_END_O,
  output logic Lock_O
);

  localparam logic [15:0] START_SEQ = 16'hEB90;
  localparam logic [63:0] TAIL_SEQ  = 64'hC5C5C5C5C5C5C579;
  // g(x) = x^7 + x^6 + x^2 + 1; the x^7 term is implied by the shift-out.
  localparam logic [6:0]  GEN_LOW   = 7'h45;

  // Receive side hunts/collects; processing side checks/outputs the hold
  // register, so a new block can be collected while the previous one drains.
  typedef enum logic {SEARCH, COLLECT} rx_state_t;
  typedef enum logic [1:0] {IDLE, CHECK, OUTPUT} proc_state_t;

  rx_state_t   rx_state;
  proc_state_t proc_state;

  // Only the previous 15 bits are kept; the 16th is the incoming BitI.
  logic [14:0] search_reg;
  // Likewise the collect register keeps 63 bits; BitI completes the block.
  logic [62:0] collect_reg;
  logic [63:0] hold_reg;
  logic [5:0]  bit_cnt;
  logic [5:0]  out_cnt;

  logic [63:0] block_next;
  logic [62:0] codeword;
  logic [6:0]  rem_hold;
  logic [63:0] hold_fixed;
  logic        check_done;
  logic        check_good;

  // Remainder of the 63-bit codeword (first bit = highest power) mod g(x),
  // evaluated Horner-style: r = r*x + bit, reducing x^7 back into the field.
  function automatic logic [6:0] bch_remainder(input logic [62:0] cw);
    logic [6:0] r;
    r = 7'd0;
    for (int i = 62; i >= 0; i--) begin
      r = {r[5:0], cw[i]} ^ (r[6] ? GEN_LOW : 7'd0);
    end
    return r;
  endfunction

`ifdef TC_BCH_CORRECT_EN
  logic [6:0] syndrome;
  logic [5:0] step_cnt;
  logic       found;
  logic       zero_rem;
  logic [6:0] syn_cur;
  logic [6:0] syn_rot;
  logic       hit;

  function automatic logic [6:0] mul_x(input logic [6:0] s);
    return {s[5:0], 1'b0} ^ (s[6] ? GEN_LOW : 7'd0);
  endfunction
`endif

  // Block assembly, parity re-inversion and the check/correct decision.
  always_comb begin
    block_next = {collect_reg, BitI};
    codeword   = {hold_reg[63:8], ~hold_reg[7:1]};
    rem_hold   = bch_remainder(codeword);
    hold_fixed = hold_reg;
`ifdef TC_BCH_CORRECT_EN
    // Step 0 seeds the rotation with the fresh remainder. A single error at
    // codeword power j gives x^j, which reaches 1 after k = 63-j rotations,
    // i.e. at step k-1, so the bit to flip is hold index 63-step.
    syn_cur = (step_cnt == 6'd0) ? rem_hold : syndrome;
    syn_rot = mul_x(syn_cur);
    hit     = (syn_rot == 7'd1) && !found;
    if (hit) begin
      hold_fixed = hold_reg ^ (64'd1 << (6'd63 - step_cnt));
    end
    check_done = (step_cnt == 6'd62);
    check_good = zero_rem || found || hit;
`else
    check_done = 1'b1;
    check_good = (rem_hold == 7'd0);
`endif
  end

  // Both state machines share one register block. The processing side is
  // written last so an uncorrectable block overrides any receive activity
  // in the same cycle (it clears the collect state and drops lock).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_state    <= SEARCH;
      proc_state  <= IDLE;
      search_reg  <= '0;
      collect_reg <= '0;
      hold_reg    <= '0;
      bit_cnt     <= '0;
      out_cnt     <= '0;
      DataO       <= 1'b0;
      En_DataO    <= 1'b0;
      Block_ErrO  <= 1'b0;
      IP_END_O    <= 1'b0;
      Lock_O      <= 1'b0;
`ifdef TC_BCH_CORRECT_EN
      syndrome    <= '0;
      step_cnt    <= '0;
      found       <= 1'b0;
      zero_rem    <= 1'b0;
`endif
    end else begin
      IP_END_O   <= 1'b0;
      Block_ErrO <= 1'b0;

      case (rx_state)
        SEARCH: begin
          if (BitEn) begin
            if ({search_reg, BitI} == START_SEQ) begin
              Lock_O      <= 1'b1;
              search_reg  <= '0;
              collect_reg <= '0;
              bit_cnt     <= '0;
              rx_state    <= COLLECT;
            end else begin
              search_reg <= {search_reg[13:0], BitI};
            end
          end
        end
        COLLECT: begin
          if (BitEn) begin
            if (bit_cnt != 6'd63) begin
              collect_reg <= block_next[62:0];
              bit_cnt     <= bit_cnt + 6'd1;
            end else begin
              collect_reg <= '0;
              bit_cnt     <= '0;
              if (block_next == TAIL_SEQ) begin
                IP_END_O <= 1'b1;
                Lock_O   <= 1'b0;
                rx_state <= SEARCH;
              end else if (proc_state == IDLE) begin
                hold_reg   <= block_next;
                proc_state <= CHECK;
`ifdef TC_BCH_CORRECT_EN
                step_cnt   <= '0;
                found      <= 1'b0;
`endif
              end else begin
                // Previous block still busy: the new block is lost.
                Block_ErrO <= 1'b1;
                Lock_O     <= 1'b0;
                rx_state   <= SEARCH;
              end
            end
          end
        end
        default: rx_state <= SEARCH;
      endcase

      case (proc_state)
        CHECK: begin
`ifdef TC_BCH_CORRECT_EN
          syndrome <= syn_rot;
          step_cnt <= step_cnt + 6'd1;
          hold_reg <= hold_fixed;
          if (step_cnt == 6'd0) begin
            zero_rem <= (rem_hold == 7'd0);
          end
          if (hit) begin
            found <= 1'b1;
          end
`endif
          if (check_done) begin
            if (check_good) begin
              DataO      <= hold_fixed[63];
              En_DataO   <= 1'b1;
              hold_reg   <= {hold_fixed[62:0], 1'b0};
              out_cnt    <= 6'd1;
              proc_state <= OUTPUT;
            end else begin
              Block_ErrO  <= 1'b1;
              Lock_O      <= 1'b0;
              rx_state    <= SEARCH;
              collect_reg <= '0;
              bit_cnt     <= '0;
              proc_state  <= IDLE;
            end
          end
        end
        OUTPUT: begin
          if (out_cnt == 6'd56) begin
            DataO      <= 1'b0;
            En_DataO   <= 1'b0;
            out_cnt    <= '0;
            proc_state <= IDLE;
          end else begin
            DataO    <= hold_reg[63];
            hold_reg <= {hold_reg[62:0], 1'b0};
            out_cnt  <= out_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
